// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: top-level game sequencing for the maze game.
// Tracks the play phase, frame timers, candy count, score, lives and level,
// and drives per-enemy fright flags and respawn/level strobes.
// Optional feature macro: GAME_FLOW_FRIGHT_EN enables power-cookie fright mode
// (BLUE_GHOST_MODE, frightened flags, enemy eating). Undefined: power cookies
// only score and every enemy hit is fatal.

package game_flow_pkg;

  typedef enum logic [2:0] {
    LOADING,
    READY,
    GAME_PLAY,
    BLUE_GHOST_MODE,
    FAIL,
    WIN,
    FINISH
  } game_mode_t;

  typedef enum logic [2:0] {
    SOUND_LOADING,
    SOUND_READY,
    SOUND_GAME_PLAY,
    SOUND_FAIL,
    SOUND_WIN
  } sound_t;

endpackage

module game_flow_ctrl
  import game_flow_pkg::*;
#(
  parameter int unsigned NUM_ENEMIES    = 4,
  parameter int unsigned LIVES          = 3,
  parameter int unsigned CANDY_COUNT    = 244,
  parameter int unsigned LOADING_FRAMES = 60,
  parameter int unsigned DEATH_FRAMES   = 120,
  parameter int unsigned WIN_FRAMES     = 120,
  parameter int unsigned FRIGHT_FRAMES  = 360,
  parameter int unsigned SCORE_W        = 16
) (
  input  logic                   vga_pix_clk,
  input  logic                   rst,
  input  logic                   frame_stb,
  input  logic                   any_btn,
  input  logic                   ate_candy_stb,
  input  logic                   ate_power_stb,
  input  logic [NUM_ENEMIES-1:0] enemy_hit,
  output game_mode_t             mode,
  output sound_t                 sound_type,
  output logic                   move_en,
  output logic [NUM_ENEMIES-1:0] frightened,
  output logic [NUM_ENEMIES-1:0] enemy_eaten_stb,
  output logic                   respawn_stb,
  output logic                   level_clear_stb,
  output logic [SCORE_W-1:0]     score,
  output logic [2:0]             lives,
  output logic [3:0]             level
);

  localparam int unsigned MaxLd     = (LOADING_FRAMES > DEATH_FRAMES) ? LOADING_FRAMES
                                                                      : DEATH_FRAMES;
  localparam int unsigned MaxWf     = (WIN_FRAMES > FRIGHT_FRAMES) ? WIN_FRAMES : FRIGHT_FRAMES;
  localparam int unsigned MaxFrames = (MaxLd > MaxWf) ? MaxLd : MaxWf;
  localparam int unsigned TimerW    = $clog2(MaxFrames + 1);
  localparam int unsigned CandyW    = $clog2(CANDY_COUNT + 1);

  game_mode_t             mode_q, mode_d;
  sound_t                 sound_q, sound_d;
  logic [TimerW-1:0]      timer_q, timer_d;
  logic [CandyW-1:0]      candy_q, candy_d;
  logic [1:0]             k_q, k_d;
  logic [SCORE_W-1:0]     score_q, score_d;
  logic [2:0]             lives_q, lives_d;
  logic [3:0]             level_q, level_d;
  logic [NUM_ENEMIES-1:0] fright_q, fright_d;
  logic [NUM_ENEMIES-1:0] eaten_q, eaten_d;
  logic                   respawn_q, respawn_d;
  logic                   clear_q, clear_d;
  logic                   move_en_q, move_en_d;

  logic                   fatal;
  logic                   restart;
  logic [31:0]            add;
  logic [SCORE_W+31:0]    score_sum;
`ifdef GAME_FLOW_FRIGHT_EN
  logic [NUM_ENEMIES-1:0] eat_hit;
`endif

  function automatic sound_t sound_of(input game_mode_t m);
    sound_t s;
    unique case (m)
      LOADING:                    s = SOUND_LOADING;
      READY:                      s = SOUND_READY;
      GAME_PLAY, BLUE_GHOST_MODE: s = SOUND_GAME_PLAY;
      WIN:                        s = SOUND_WIN;
      default:                    s = SOUND_FAIL;
    endcase
    return s;
  endfunction

  // Next-state, scoring and strobe generation; event precedence is
  // level completion > fatal hit > eaten hit > power cookie > fright timeout.
  always_comb begin
    mode_d    = mode_q;
    timer_d   = timer_q;
    candy_d   = candy_q;
    k_d       = k_q;
    lives_d   = lives_q;
    level_d   = level_q;
    fright_d  = fright_q;
    eaten_d   = '0;
    respawn_d = 1'b0;
    clear_d   = 1'b0;
    fatal     = 1'b0;
    restart   = 1'b0;
    add       = 32'd0;
    score_sum = '0;
`ifdef GAME_FLOW_FRIGHT_EN
    eat_hit   = '0;
`endif
    move_en_d = frame_stb && ((mode_q == GAME_PLAY) || (mode_q == BLUE_GHOST_MODE));

    unique case (mode_q)
      LOADING: begin
        if (frame_stb && (timer_q == TimerW'(LOADING_FRAMES - 1))) mode_d = READY;
      end
      READY: begin
        if (any_btn) mode_d = GAME_PLAY;
      end
      GAME_PLAY, BLUE_GHOST_MODE: begin
        if (ate_candy_stb) begin
          candy_d = candy_q + CandyW'(1);
          add     = add + 32'd1;
        end
        if (ate_power_stb) add = add + 32'd5;
        // Outside fright mode fright_q is all zero, so any hit is fatal.
        fatal = |(enemy_hit & ~fright_q);
        if (ate_candy_stb && (candy_q == CandyW'(CANDY_COUNT - 1))) begin
          mode_d = WIN;
        end else if (fatal) begin
          mode_d = FAIL;
        end else begin
`ifdef GAME_FLOW_FRIGHT_EN
          eat_hit = enemy_hit & fright_q;
          // Simultaneous eats are scored in index order, each with its own k.
          for (int unsigned i = 0; i < NUM_ENEMIES; i++) begin
            if (eat_hit[i]) begin
              eaten_d[i]  = 1'b1;
              fright_d[i] = 1'b0;
              add         = add + (32'd20 << k_d);
              if (k_d != 2'd3) k_d = k_d + 2'd1;
            end
          end
          if (!(|eat_hit) && ate_power_stb) begin
            mode_d   = BLUE_GHOST_MODE;
            fright_d = '1;
            k_d      = 2'd0;
            restart  = 1'b1;
          end
`endif
          if ((mode_q == BLUE_GHOST_MODE) && !restart && frame_stb &&
              (timer_q == TimerW'(FRIGHT_FRAMES - 1))) begin
            mode_d = GAME_PLAY;
          end
        end
      end
      FAIL: begin
        if (frame_stb && (timer_q == TimerW'(DEATH_FRAMES - 1))) begin
          lives_d = lives_q - 3'd1;
          if (lives_q == 3'd1) begin
            mode_d = FINISH;
          end else begin
            mode_d    = READY;
            respawn_d = 1'b1;
          end
        end
      end
      WIN: begin
        if (frame_stb && (timer_q == TimerW'(WIN_FRAMES - 1))) begin
          mode_d    = READY;
          level_d   = level_q + 4'd1;
          candy_d   = '0;
          clear_d   = 1'b1;
          respawn_d = 1'b1;
        end
      end
      FINISH: begin
      end
      default: mode_d = LOADING;
    endcase

    if (mode_d != BLUE_GHOST_MODE) fright_d = '0;

    if ((mode_d != mode_q) || restart) begin
      timer_d = '0;
    end else if (frame_stb) begin
      timer_d = timer_q + TimerW'(1);
    end

    score_sum = {32'd0, score_q} + {{SCORE_W{1'b0}}, add};
    if (|score_sum[SCORE_W+31:SCORE_W]) begin
      score_d = '1;
    end else begin
      score_d = score_sum[SCORE_W-1:0];
    end

    sound_d = sound_of(mode_d);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge vga_pix_clk) begin
    if (rst) begin
      mode_q    <= LOADING;
      sound_q   <= SOUND_LOADING;
      timer_q   <= '0;
      candy_q   <= '0;
      k_q       <= 2'd0;
      score_q   <= '0;
      lives_q   <= 3'(LIVES);
      level_q   <= 4'd0;
      fright_q  <= '0;
      eaten_q   <= '0;
      respawn_q <= 1'b0;
      clear_q   <= 1'b0;
      move_en_q <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      sound_q   <= sound_d;
      timer_q   <= timer_d;
      candy_q   <= candy_d;
      k_q       <= k_d;
      score_q   <= score_d;
      lives_q   <= lives_d;
      level_q   <= level_d;
      fright_q  <= fright_d;
      eaten_q   <= eaten_d;
      respawn_q <= respawn_d;
      clear_q   <= clear_d;
      move_en_q <= move_en_d;
    end
  end

  assign mode            = mode_q;
  assign sound_type      = sound_q;
  assign move_en         = move_en_q;
  assign frightened      = fright_q;
  assign enemy_eaten_stb = eaten_q;
  assign respawn_stb     = respawn_q;
  assign level_clear_stb = clear_q;
  assign score           = score_q;
  assign lives           = lives_q;
  assign level           = level_q;

endmodule
